// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package ifu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            misalign;
    } ifq_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous instruction queue; clear wins over push and pop in the same cycle.
module ifu_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  ifq_entry_t               push_data,
    input  logic                     pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     valid,
    output ifq_entry_t               head
);

    localparam int PW = $clog2(DEPTH);

    ifq_entry_t       mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign valid = (count != '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/ifu_fetch.sv
// Fetch stage: one outstanding imem read at a time, results queued with their PC for decode.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int DATAWIDTH = XLEN,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATAWIDTH-1:0] pc_in,
    output logic                 pc_accept,
    input  logic                 flush,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [DATAWIDTH-1:0] imem_req_addr,
    input  logic                 imem_resp_valid,
    input  logic [DATAWIDTH-1:0] imem_resp_data,
    output logic                 ifq_valid,
    input  logic                 ifq_ready,
    output logic [DATAWIDTH-1:0] ifq_pc,
    output logic [DATAWIDTH-1:0] ifq_instr,
    output logic                 ifq_misalign
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_state_e         state;
    logic [DATAWIDTH-1:0] req_addr;
    logic [DATAWIDTH-1:0] req_pc;
    logic                 drop;
    logic [CW-1:0]        count;
    logic                 credit;
    logic                 push_mis;
    logic                 push_resp;
    logic                 push;
    ifq_entry_t           push_data;
    ifq_entry_t           head;

    // An in-flight fetch reserves a slot so a later push can never overflow.
    assign credit    = (count + CW'(state != IDLE)) < DEPTH_C;
    assign pc_accept = rst && (state == IDLE) && credit && !flush;
    assign push_mis  = pc_accept && (pc_in[1:0] != 2'b00);
    assign push_resp = (state == WAIT) && imem_resp_valid && !drop && !flush;
    assign push      = push_mis || push_resp;

    always_comb begin
        push_data = '{pc: req_pc, instr: imem_resp_data, misalign: 1'b0};
        if (push_mis) begin
            push_data = '{pc: pc_in, instr: NOP_INSTR, misalign: 1'b1};
        end
    end

    // The request is never withdrawn; a flush only marks its response for discard.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            req_addr <= '0;
            req_pc   <= '0;
            drop     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_accept) begin
                        req_addr <= pc_in;
                        req_pc   <= pc_in;
                        if (pc_in[1:0] == 2'b00) begin
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        drop  <= 1'b0;
                        state <= IDLE;
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    ifu_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .push     (push),
        .push_data(push_data),
        .pop      (ifq_valid && ifq_ready),
        .count    (count),
        .valid    (ifq_valid),
        .head     (head)
    );

    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = req_addr;
    assign ifq_pc         = head.pc;
    assign ifq_instr      = head.instr;
    assign ifq_misalign   = head.misalign;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a PC-register model and a simple instruction-memory model.
module tb_ifu_fetch;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_accept;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        ifq_valid;
    logic        ifq_ready;
    logic [31:0] ifq_pc;
    logic [31:0] ifq_instr;
    logic        ifq_misalign;

    int          tests = 0;
    int          fails = 0;
    int          resp_cnt = 0;
    int          resp_delay = 1;
    logic [31:0] resp_addr = '0;
    logic [31:0] flush_target = '0;
    bit          use_dead = 1'b0;
    ifq_entry_t  exp_q[$];

    ifu_fetch #(.DATAWIDTH(32), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_in          (pc_in),
        .pc_accept      (pc_accept),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .ifq_valid      (ifq_valid),
        .ifq_ready      (ifq_ready),
        .ifq_pc         (ifq_pc),
        .ifq_instr      (ifq_instr),
        .ifq_misalign   (ifq_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr, input logic mis);
        exp_q.push_back('{pc: pc, instr: instr, misalign: mis});
    endtask

    // One clock: sample handshakes before the edge, then update the PC and memory models.
    task automatic tick();
        logic        hs;
        logic        acc;
        logic        fl;
        logic [31:0] ha;
        ifq_entry_t  e;
        #1;
        hs  = imem_req_valid && imem_req_ready;
        ha  = imem_req_addr;
        acc = pc_accept;
        fl  = flush;
        if (ifq_valid && ifq_ready) begin
            tests++;
            assert (exp_q.size() != 0)
            else begin
                fails++;
                $error("[TB] FAIL pop_unexpected: observed pc %h expected no entry", ifq_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pop_pc", ifq_pc, e.pc);
                chk("pop_instr", ifq_instr, e.instr);
                chk("pop_misalign", {31'b0, ifq_misalign}, {31'b0, e.misalign});
            end
        end
        @(posedge clk);
        #1;
        if (fl) pc_in = flush_target;
        else if (acc) pc_in = pc_in + 32'd4;
        imem_resp_valid = 1'b0;
        if (hs) begin
            resp_cnt  = resp_delay;
            resp_addr = ha;
        end
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = use_dead ? 32'hDEAD_BEEF : (32'hD000_0000 | resp_addr);
            end
        end
        #1;
    endtask

    task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
        chk({tag, "_valid"}, {31'b0, imem_req_valid}, {31'b0, v});
        if (v) chk({tag, "_addr"}, imem_req_addr, a);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc, input logic [31:0] instr, input logic mis);
        chk({tag, "_valid"}, {31'b0, ifq_valid}, 32'd1);
        chk({tag, "_pc"}, ifq_pc, pc);
        chk({tag, "_instr"}, ifq_instr, instr);
        chk({tag, "_mis"}, {31'b0, ifq_misalign}, {31'b0, mis});
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_accept"}, {31'b0, pc_accept}, 32'd0);
        chk({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'd0);
        chk({tag, "_req_addr"}, imem_req_addr, 32'd0);
        chk({tag, "_ifq_valid"}, {31'b0, ifq_valid}, 32'd0);
        chk({tag, "_ifq_pc"}, ifq_pc, 32'd0);
        chk({tag, "_ifq_instr"}, ifq_instr, 32'd0);
        chk({tag, "_ifq_mis"}, {31'b0, ifq_misalign}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        pc_in = 32'h0;
        flush = 1'b0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        ifq_ready = 1'b1;

        @(posedge clk);
        @(posedge clk);
        #2;
        chk_all_zero("reset");
        rst = 1'b1;
        #1;

        // Zero-wait memory: pc 0,4,8,12, one fetch every three cycles.
        for (int k = 0; k < 4; k++) begin
            expect_entry(32'(4 * k), 32'hD000_0000 | 32'(4 * k), 1'b0);
            chk("t1_accept_idle", {31'b0, pc_accept}, 32'd1);
            chk("t1_req_idle", {31'b0, imem_req_valid}, 32'd0);
            tick();
            chk_req("t1_req", 1'b1, 32'(4 * k));
            chk("t1_accept_req", {31'b0, pc_accept}, 32'd0);
            tick();
            chk("t1_accept_wait", {31'b0, pc_accept}, 32'd0);
            chk("t1_req_wait", {31'b0, imem_req_valid}, 32'd0);
            tick();
            chk_head("t1_head", 32'(4 * k), 32'hD000_0000 | 32'(4 * k), 1'b0);
        end

        // Memory stalls the request at 0x10 for five cycles.
        imem_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk_req("t2_stall", 1'b1, 32'h10);
            chk("t2_accept", {31'b0, pc_accept}, 32'd0);
            tick();
        end

        // Decode stalls: two entries fill the queue and fetching stops.
        imem_req_ready = 1'b1;
        ifq_ready = 1'b0;
        expect_entry(32'h10, 32'hD000_0010, 1'b0);
        expect_entry(32'h14, 32'hD000_0014, 1'b0);
        chk_req("t3_hs", 1'b1, 32'h10);
        tick();
        tick();
        chk_head("t3_h10", 32'h10, 32'hD000_0010, 1'b0);
        chk("t3_accept1", {31'b0, pc_accept}, 32'd1);
        tick();
        chk_req("t3_req14", 1'b1, 32'h14);
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t3_full_accept", {31'b0, pc_accept}, 32'd0);
            chk("t3_full_req", {31'b0, imem_req_valid}, 32'd0);
            chk_head("t3_full_head", 32'h10, 32'hD000_0010, 1'b0);
            tick();
        end
        ifq_ready = 1'b1;
        tick();
        chk("t3_resume_accept", {31'b0, pc_accept}, 32'd1);
        chk_head("t3_h14", 32'h14, 32'hD000_0014, 1'b0);
        tick();
        chk_req("t3_req18", 1'b1, 32'h18);
        tick();
        tick();
        chk_head("t3_h18", 32'h18, 32'hD000_0018, 1'b0);

        // Flush in WAIT: queued 0x18 and the late 0xDEADBEEF response are both discarded.
        ifq_ready = 1'b0;
        resp_delay = 2;
        use_dead = 1'b1;
        tick();
        chk_req("t4_req1c", 1'b1, 32'h1C);
        tick();
        flush = 1'b1;
        flush_target = 32'h100;
        #1;
        chk("t4_flush_accept", {31'b0, pc_accept}, 32'd0);
        tick();
        flush = 1'b0;
        chk("t4_cleared", {31'b0, ifq_valid}, 32'd0);
        chk("t4_resp_arrives", {31'b0, imem_resp_valid}, 32'd1);
        tick();
        chk("t4_dropped", {31'b0, ifq_valid}, 32'd0);
        chk("t4_accept", {31'b0, pc_accept}, 32'd1);
        resp_delay = 1;
        use_dead = 1'b0;
        ifq_ready = 1'b1;
        expect_entry(32'h100, 32'hD000_0100, 1'b0);
        tick();
        chk_req("t4_req100", 1'b1, 32'h100);
        tick();
        tick();
        chk_head("t4_h100", 32'h100, 32'hD000_0100, 1'b0);

        // Flush in REQ with the handshake delayed two cycles.
        imem_req_ready = 1'b0;
        tick();
        flush = 1'b1;
        flush_target = 32'h200;
        chk_req("t5_req104", 1'b1, 32'h104);
        tick();
        flush = 1'b0;
        chk_req("t5_hold", 1'b1, 32'h104);
        tick();
        chk_req("t5_hold2", 1'b1, 32'h104);
        imem_req_ready = 1'b1;
        tick();
        chk("t5_wait_req", {31'b0, imem_req_valid}, 32'd0);
        tick();
        chk("t5_swallowed", {31'b0, ifq_valid}, 32'd0);
        chk("t5_accept", {31'b0, pc_accept}, 32'd1);
        tick();
        chk_req("t5_req200", 1'b1, 32'h200);
        tick();
        rst = 1'b0;
        #1;
        chk_all_zero("t5_async");
        imem_resp_valid = 1'b0;
        resp_cnt = 0;
        pc_in = 32'h102;
        rst = 1'b1;
        #1;

        // Misaligned PC becomes a fault entry without a memory request.
        chk("t6_accept", {31'b0, pc_accept}, 32'd1);
        expect_entry(32'h102, NOP_INSTR, 1'b1);
        tick();
        chk("t6_no_req", {31'b0, imem_req_valid}, 32'd0);
        chk_head("t6_head", 32'h102, 32'h0000_0013, 1'b1);
        pc_in = 32'h300;
        expect_entry(32'h300, 32'hD000_0300, 1'b0);
        tick();
        chk_req("t6_req300", 1'b1, 32'h300);
        tick();
        tick();
        chk_head("t6_h300", 32'h300, 32'hD000_0300, 1'b0);
        pc_in = 32'h400;
        ifq_ready = 1'b1;
        tick();
        chk("t6_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC (pc_in), issues one instruction-memory read at a time over a valid/ready request channel, and pairs each returned word with its PC.
- Buffers fetched {pc, instr, misalign} entries in a small FIFO for decode.
- Drives pc_accept, which the next-PC logic uses to advance or hold the PC.

Parameters:
- DATAWIDTH, 32, width of PC, address and instruction.
- DEPTH, 2, instruction-queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- pc_in  in  DATAWIDTH  current PC from the PC register.
- pc_accept  out  1  pc_in consumed this cycle; next-PC logic advances only when high.
- flush  in  1  redirect; discard all queued and in-flight fetches.
- imem_req_valid  out  1  memory read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  DATAWIDTH  read address.
- imem_resp_valid  in  1  read data valid.
- imem_resp_data  in  DATAWIDTH  read data.
- ifq_valid  out  1  queue head valid toward decode.
- ifq_ready  in  1  decode takes head.
- ifq_pc  out  DATAWIDTH  PC of head entry.
- ifq_instr  out  DATAWIDTH  instruction of head entry.
- ifq_misalign  out  1  head entry is a misaligned-PC fault.

Behaviour:
- Reset (rst=0, async):
  - State is IDLE, FIFO is empty and the drop flag is clear.
  - All outputs are 0, including pc_accept, imem_req_valid, imem_req_addr, ifq_valid, ifq_pc, ifq_instr and ifq_misalign.
  - Instruction memory shares this reset, so no response survives a reset.
- Credit is true when fifo_count + (state != IDLE) < DEPTH.
- IDLE:
  - If credit and !flush: latch req_addr = req_pc = pc_in and pulse pc_accept=1.
  - If pc_in[1:0] != 0: push {pc_in, NOP_INSTR, 1} directly, issue no memory request, and stay in IDLE.
  - Otherwise go to REQ.
  - imem_resp_valid in IDLE is ignored.
- REQ:
  - imem_req_valid=1 and imem_req_addr=req_addr.
  - Both are held stable until imem_req_ready is high; the request is never withdrawn, even on flush.
  - Flush while in REQ sets the drop flag.
  - On handshake, go to WAIT.
- WAIT:
  - On imem_resp_valid, if !drop and !flush, push {req_pc, imem_resp_data, 0}.
  - Otherwise discard the response.
  - In either case clear drop and return to IDLE.
  - A response can arrive no earlier than the cycle after the request handshake.
- Flush (any state):
  - The FIFO is cleared that cycle; a simultaneous push or pop is void and ifq_valid=0 next cycle.
  - pc_accept is forced to 0.
  - Next-PC logic loads the target into the PC register regardless of pc_accept, so pc_in equals the target one cycle after flush.
- FIFO rules:
  - Push and pop in the same cycle leave the count unchanged.
  - Pop occurs when ifq_valid && ifq_ready.
  - Pointers wrap modulo DEPTH.
  - Credit guarantees a push never hits a full FIFO.
  - Head outputs are registered FIFO contents.
- Latency and throughput with zero-wait memory (ready=1, response next cycle):
  - Cycle 0: pc_accept.
  - Cycle 1: request handshake.
  - Cycle 2: response and push.
  - Cycle 3: ifq_valid.
  - Throughput is one fetch per 3 cycles.

Decomposition:
- Package ifu_pkg holds:
  - NOP_INSTR = 32'h0000_0013.
  - The fetch_state_e enum {IDLE, REQ, WAIT}.
  - The ifq_entry_t struct {pc, instr, misalign}.
- One sub-module, ifu_fifo: a synchronous FIFO with DEPTH, push/pop, synchronous clear, count and head outputs, sharing clk/rst.

Test Plan:
1. Release reset with zero-wait memory and pc_in stepping 0, 4, 8 on pc_accept -> imem_req_addr is 0, 4, 8; ifq yields (0, D0), (4, D4), (8, D8); pc_accept pulses every 3 cycles.
2. imem_req_ready=0 for 5 cycles with addr 0x10 -> imem_req_valid=1 and addr=0x10 stay stable, with no pc_accept pulse until the handshake.
3. ifq_ready=0 -> after 2 entries, imem_req_valid and pc_accept stay 0; ifq_ready=1 -> one pop frees credit and fetching resumes in order.
4. Flush in WAIT with response 0xDEADBEEF arriving the next cycle -> response dropped, FIFO empty; next request uses target pc_in=0x100.
5. Flush in REQ with ready delayed 2 cycles -> handshake still completes, the response is swallowed, and no entry is pushed. Then rst=0 mid-WAIT -> all outputs are 0 immediately (async).
6. pc_in=0x102 -> no imem request; ifq entry is {0x102, 0x0000_0013, misalign=1}; the next fetch then proceeds normally.
